lsu_mem_initiator: RTL and testbench

// - Load/store initiator for the M stage: turns one M-stage memory op into a req/gnt/rvalid transaction on the data-memory port.
// - Drives byte enables; aligns and sign/zero-extends load data; stalls the pipeline while an op is in flight.
// - Delivers one registered writeback beat (rd, regwrite, data) to the W stage.

---
 rtl/lsu_mem_initiator.sv | 233 +++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// M-stage load/store initiator: issues one req/gnt/rvalid data-memory transaction per op,
// formats load data and returns a single registered writeback beat.
module lsu_mem_initiator #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid_i,
    input  logic              m_we_i,
    input  logic [1:0]        m_size_i,
    input  logic              m_unsigned_i,
    input  logic [31:0]       m_addr_i,
    input  logic [31:0]       m_wdata_i,
    input  logic [4:0]        m_rd_i,
    input  logic              m_regwrite_i,
    output logic              stall_m_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              w_valid_o,
    output logic [4:0]        w_rd_o,
    output logic              w_regwrite_o,
    output logic [31:0]       w_rdata_o,
    output logic              misalign_err_o,
    output logic              bus_err_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d, off_q, off_d;
    logic               uns_q, uns_d, rw_q, rw_d;
    logic [4:0]         rd_q, rd_d;
    logic               w_valid_q, w_valid_d, w_rw_q, w_rw_d;
    logic [4:0]         w_rd_q, w_rd_d;
    logic [31:0]        w_rdata_q, w_rdata_d;
    logic               mis_q, mis_d, bus_q, bus_d;
    logic               stall_c, legal_c, tmo_c;
    logic               unused_addr_c;

    assign unused_addr_c = ^m_addr_i[31:ADDR_W+2];

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        unique case (sz)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        unique case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        unique case (sz)
            2'b00:   fmt_load = {{24{~uns & b[7]}}, b};
            2'b01:   fmt_load = {{16{~uns & h[15]}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    // Natural alignment check; size 11 never legal.
    always_comb begin
        unique case (m_size_i)
            2'b00:   legal_c = 1'b1;
            2'b01:   legal_c = ~m_addr_i[0];
            2'b10:   legal_c = (m_addr_i[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
    end

    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        w_valid_d = 1'b0;
        w_rd_d    = w_rd_q;
        w_rw_d    = 1'b0;
        w_rdata_d = w_rdata_q;
        mis_d     = 1'b0;
        bus_d     = 1'b0;
        stall_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (m_valid_i && legal_c) begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = m_we_i;
                    addr_d  = m_addr_i[ADDR_W+1:2];
                    be_d    = lane_mask(m_size_i, m_addr_i[1:0]);
                    unique case (m_size_i)
                        2'b00:   wdata_d = {4{m_wdata_i[7:0]}};
                        2'b01:   wdata_d = {2{m_wdata_i[15:0]}};
                        default: wdata_d = m_wdata_i;
                    endcase
                    size_d  = m_size_i;
                    off_d   = m_addr_i[1:0];
                    uns_d   = m_unsigned_i;
                    rd_d    = m_rd_i;
                    rw_d    = m_regwrite_i;
                end else if (m_valid_i) begin
                    mis_d     = 1'b1;
                    w_valid_d = 1'b1;
                    w_rd_d    = m_rd_i;
                    w_rdata_d = '0;
                end
            end
            S_REQ, S_RESP: begin
                stall_c = 1'b1;
                w_rd_d  = rd_q;
                if (state_q == S_REQ && mem_gnt_i) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (we_q) begin
                        stall_c   = 1'b0;
                        state_d   = S_IDLE;
                        w_valid_d = 1'b1;
                        w_rw_d    = rw_q;
                        w_rdata_d = '0;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (state_q == S_RESP && mem_rvalid_i) begin
                    stall_c   = 1'b0;
                    state_d   = S_IDLE;
                    w_valid_d = 1'b1;
                    w_rw_d    = rw_q;
                    w_rdata_d = fmt_load(mem_rdata_i, size_q, off_q, uns_q);
                end else if (tmo_c) begin
                    // Abandon the op: error beat with regwrite suppressed.
                    stall_c   = 1'b0;
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    bus_d     = 1'b1;
                    w_valid_d = 1'b1;
                    w_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            w_valid_q <= 1'b0;
            w_rd_q    <= '0;
            w_rw_q    <= 1'b0;
            w_rdata_q <= '0;
            mis_q     <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            w_valid_q <= w_valid_d;
            w_rd_q    <= w_rd_d;
            w_rw_q    <= w_rw_d;
            w_rdata_q <= w_rdata_d;
            mis_q     <= mis_d;
            bus_q     <= bus_d;
        end
    end

    assign stall_m_o      = rst & stall_c;
    assign mem_req_o      = req_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_be_o       = be_q;
    assign mem_wdata_o    = wdata_q;
    assign w_valid_o      = w_valid_q;
    assign w_rd_o         = w_rd_q;
    assign w_regwrite_o   = w_rw_q;
    assign w_rdata_o      = w_rdata_q;
    assign misalign_err_o = mis_q;
    assign bus_err_o      = bus_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed scenarios plus randomized ops checked against
// an arithmetic model of lane selection, replication and extension.
module tb_lsu_mem_initiator;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              m_valid, m_we, m_unsigned, m_regwrite;
    logic [1:0]        m_size;
    logic [31:0]       m_addr, m_wdata;
    logic [4:0]        m_rd;
    logic              stall_m, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              w_valid, w_regwrite, misalign_err, bus_err;
    logic [4:0]        w_rd;
    logic [31:0]       w_rdata;

    int checks = 0;
    int errors = 0;
    int obs_stall, obs_req_cycles;
    logic [31:0] obs_be, obs_wdata, obs_addr, obs_wrdata;

    lsu_mem_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_valid_i(m_valid), .m_we_i(m_we), .m_size_i(m_size), .m_unsigned_i(m_unsigned),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rd_i(m_rd), .m_regwrite_i(m_regwrite),
        .stall_m_o(stall_m), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .w_valid_o(w_valid), .w_rd_o(w_rd), .w_regwrite_o(w_regwrite), .w_rdata_o(w_rdata),
        .misalign_err_o(misalign_err), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte counts and shifts rather than per-size cases.
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic is_legal(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b0;
        return (addr % nbytes(size)) == 0;
    endfunction

    function automatic logic [31:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
        int n;
        int off;
        n   = nbytes(size);
        off = int'(addr % 4);
        return 32'((((1 << n) - 1) << off) & 15);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] d);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = nbytes(size);
        v = d >> (8 * (addr % 4));
        if (n == 4) mask = 32'hFFFF_FFFF;
        else        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic rw);
        m_valid = 1'b1; m_we = we; m_size = size; m_unsigned = uns;
        m_addr = addr; m_wdata = wdata; m_rd = rd; m_regwrite = rw;
    endtask

    // One complete op starting at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata);
        logic [31:0] eload;
        obs_stall = 0;
        obs_req_cycles = 0;
        @(negedge clk);
        drive_op(we, size, uns, addr, wdata, rd, rw);
        #1;
        if (!is_legal(size, addr)) begin
            chk("illegal_stall", 32'(stall_m), 32'd0);
            @(negedge clk);
            m_valid = 1'b0;
            #1;
            chk("misalign_pulse", 32'(misalign_err), 32'd1);
            chk("illegal_wvalid", 32'(w_valid), 32'd1);
            chk("illegal_wregwrite", 32'(w_regwrite), 32'd0);
            chk("illegal_wrdata", w_rdata, 32'd0);
            chk("illegal_wrd", 32'(w_rd), 32'(rd));
            chk("illegal_no_req", 32'(mem_req), 32'd0);
        end else begin
            chk("accept_stall", 32'(stall_m), 32'd1);
            obs_stall++;
            for (int k = 0; k <= gnt_wait; k++) begin
                @(negedge clk);
                if (k == gnt_wait) mem_gnt = 1'b1;
                #1;
                obs_req_cycles++;
                obs_be = 32'(mem_be); obs_wdata = mem_wdata; obs_addr = 32'(mem_addr);
                chk("req_high", 32'(mem_req), 32'd1);
                chk("req_we", 32'(mem_we), 32'(we));
                chk("req_addr", obs_addr, (addr >> 2) & 32'h3FF);
                chk("req_be", obs_be, exp_be(size, addr));
                if (we) chk("req_wdata", obs_wdata, exp_wdata(size, wdata));
                chk("req_stall", 32'(stall_m), (k == gnt_wait && we) ? 32'd0 : 32'd1);
                if (stall_m) obs_stall++;
            end
            @(negedge clk);
            mem_gnt = 1'b0;
            if (!we) begin
                for (int k = 0; k <= rv_wait; k++) begin
                    if (k > 0) @(negedge clk);
                    if (k == rv_wait) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end else begin
                        mem_rdata  = $urandom;
                    end
                    #1;
                    chk("resp_req_low", 32'(mem_req), 32'd0);
                    chk("resp_stall", 32'(stall_m), (k == rv_wait) ? 32'd0 : 32'd1);
                    if (stall_m) obs_stall++;
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
            m_valid = 1'b0;
            #1;
            eload = we ? 32'd0 : exp_load(size, addr, uns, rdata);
            obs_wrdata = w_rdata;
            chk("done_wvalid", 32'(w_valid), 32'd1);
            chk("done_wrd", 32'(w_rd), 32'(rd));
            chk("done_wregwrite", 32'(w_regwrite), 32'(rw));
            chk("done_wrdata", obs_wrdata, eload);
            chk("done_no_err", 32'({misalign_err, bus_err}), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("beat_one_cycle", 32'(w_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_size = 2'b00; m_unsigned = 1'b0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_regwrite = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {stall_m, mem_req, mem_we, w_valid, w_regwrite, misalign_err, bus_err},
            32'd0);
        chk("rst_bus", 32'(mem_be) | 32'(mem_addr) | mem_wdata | w_rdata | 32'(w_rd), 32'd0);
        rst = 1'b1;

        // Word load at 0x70: gnt first REQ cycle, rvalid one cycle later
        do_op(1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 5'd3, 1'b1, 0, 1, 32'hF00000F0);
        chk("t1_stall_cycles", 32'(obs_stall), 32'd3);
        chk("t1_mem_addr", obs_addr, 32'd28);
        chk("t1_wrdata", obs_wrdata, 32'hF00000F0);

        // Byte load at 0x71, signed then unsigned
        do_op(1'b0, 2'b00, 1'b0, 32'h71, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0000F000);
        chk("t2_be", obs_be, 32'b0010);
        chk("t2_signed", obs_wrdata, 32'hFFFFFFF0);
        do_op(1'b0, 2'b00, 1'b1, 32'h71, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0000F000);
        chk("t2_unsigned", obs_wrdata, 32'h000000F0);

        // Half store at 0x06 with three wait cycles before gnt
        do_op(1'b1, 2'b01, 1'b0, 32'h06, 32'h1234ABCD, 5'd0, 1'b0, 3, 0, 32'h0);
        chk("t3_be", obs_be, 32'b1100);
        chk("t3_wdata", obs_wdata, 32'hABCDABCD);
        chk("t3_req_cycles", 32'(obs_req_cycles), 32'd4);

        // Misaligned word load, then illegal size
        do_op(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);
        do_op(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);

        // Load with rvalid withheld: bus error after TIMEOUT cycles in RESP
        @(negedge clk);
        drive_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            n++;
            if (!stall_m) break;
            @(negedge clk);
        end
        chk("tmo_resp_cycles", 32'(n), 32'(TIMEOUT));
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        chk("tmo_wvalid", 32'(w_valid), 32'd1);
        chk("tmo_wregwrite", 32'(w_regwrite), 32'd0);
        chk("tmo_req_low", 32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo_pulse_one", 32'(bus_err), 32'd0);

        // Reset while in RESP, late rvalid, then a normal op
        @(negedge clk);
        drive_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd6, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_outputs", {stall_m, mem_req, mem_we, w_valid, w_regwrite, misalign_err, bus_err},
            32'd0);
        chk("mid_rst_bus", 32'(mem_be) | 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("late_rvalid_stall", 32'(stall_m), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ignored", 32'(w_valid), 32'd0);
        do_op(1'b0, 2'b01, 1'b0, 32'h82, 32'h0, 5'd6, 1'b1, 1, 2, 32'h8001_1234);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            logic we;
            logic [1:0] sz;
            we = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            do_op(we, sz, 1'($urandom), $urandom & 32'hFFF, $urandom, 5'($urandom), ~we,
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
